// File: rtl/uart_pkg.sv
// Shared UART-side constants: ASCII codes and the hex_dump_tx state encoding.
package uart_pkg;

    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LO = 8'h61;
    localparam logic [7:0] ASCII_A_UP = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_SEP  = 3'd3,
        ST_CR   = 3'd4,
        ST_LF   = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

endpackage

// File: rtl/hex_dump_tx_nibble_to_ascii.sv
// Combinational 4-bit -> ASCII hex digit converter (module nibble_to_ascii).
// Define HEX_DUMP_UPPER_EN for uppercase letters A-F; default is lowercase a-f.
module nibble_to_ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

`ifdef HEX_DUMP_UPPER_EN
    localparam logic [7:0] LETTER_BASE = ASCII_A_UP;
`else
    localparam logic [7:0] LETTER_BASE = ASCII_A_LO;
`endif

    always_comb begin
        if (nibble < 4'd10)
            ascii = ASCII_0 + {4'd0, nibble};
        else
            ascii = LETTER_BASE + {4'd0, nibble} - 8'd10;
    end

endmodule

// File: rtl/hex_dump_tx.sv
// Pops bytes from a FWFT fifo and sends them to serial_tx as two hex digits plus
// a space, or CR LF after every BYTES_PER_LINE bytes (letter case via HEX_DUMP_UPPER_EN).
module hex_dump_tx
    import uart_pkg::*;
#(
    parameter int BYTES_PER_LINE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_empty,
    input  logic [7:0] i_data,
    output logic       o_rd,
    input  logic       i_busy,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic [7:0] o_line_cnt
);

    localparam logic [7:0] LAST_COL = 8'(BYTES_PER_LINE - 1);

    state_t     state, state_nxt;
    state_t     after_gap, after_gap_nxt;
    logic [7:0] byte_q, byte_nxt;
    logic [7:0] line_nxt, data_nxt;
    logic       rd_nxt, wr_nxt;
    logic [3:0] nibble;
    logic [7:0] digit;
    logic       last_col;

    assign last_col = (o_line_cnt == LAST_COL);
    assign nibble   = (state == ST_HI) ? byte_q[7:4] : byte_q[3:0];

    nibble_to_ascii u_digit (
        .nibble (nibble),
        .ascii  (digit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            after_gap  <= ST_IDLE;
            byte_q     <= 8'h00;
            o_rd       <= 1'b0;
            o_wr       <= 1'b0;
            o_data     <= 8'h00;
            o_line_cnt <= 8'h00;
        end else begin
            state      <= state_nxt;
            after_gap  <= after_gap_nxt;
            byte_q     <= byte_nxt;
            o_rd       <= rd_nxt;
            o_wr       <= wr_nxt;
            o_data     <= data_nxt;
            o_line_cnt <= line_nxt;
        end
    end

    // Every character write is followed by GAP, which remembers where to resume.
    always_comb begin
        state_nxt     = state;
        after_gap_nxt = after_gap;
        byte_nxt      = byte_q;
        line_nxt      = o_line_cnt;
        data_nxt      = o_data;
        rd_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!i_empty) begin
                    rd_nxt    = 1'b1;
                    byte_nxt  = i_data;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (!i_busy) begin
                    wr_nxt        = 1'b1;
                    data_nxt      = digit;
                    after_gap_nxt = ST_LO;
                    state_nxt     = ST_GAP;
                end
            end
            ST_LO: begin
                if (!i_busy) begin
                    wr_nxt        = 1'b1;
                    data_nxt      = digit;
                    after_gap_nxt = last_col ? ST_CR : ST_SEP;
                    state_nxt     = ST_GAP;
                end
            end
            ST_SEP: begin
                if (!i_busy) begin
                    wr_nxt        = 1'b1;
                    data_nxt      = ASCII_SP;
                    line_nxt      = o_line_cnt + 8'd1;
                    after_gap_nxt = ST_IDLE;
                    state_nxt     = ST_GAP;
                end
            end
            ST_CR: begin
                if (!i_busy) begin
                    wr_nxt        = 1'b1;
                    data_nxt      = ASCII_CR;
                    after_gap_nxt = ST_LF;
                    state_nxt     = ST_GAP;
                end
            end
            ST_LF: begin
                if (!i_busy) begin
                    wr_nxt        = 1'b1;
                    data_nxt      = ASCII_LF;
                    line_nxt      = 8'h00;
                    after_gap_nxt = ST_IDLE;
                    state_nxt     = ST_GAP;
                end
            end
            ST_GAP:  state_nxt = after_gap;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hex_dump_tx.sv
// Self-checking bench for hex_dump_tx: fifo and serial_tx models plus a
// character-stream reference built from the formatting rules.
module tb_hex_dump_tx;

    localparam int BPL = 4;
`ifdef HEX_DUMP_UPPER_EN
    localparam int LETTER = 65;
`else
    localparam int LETTER = 97;
`endif

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_empty;
    logic [7:0] i_data;
    logic       o_rd;
    logic       i_busy;
    logic       o_wr;
    logic [7:0] o_data;
    logic [7:0] o_line_cnt;

    hex_dump_tx #(.BYTES_PER_LINE(BPL)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_empty    (i_empty),
        .i_data     (i_data),
        .o_rd       (o_rd),
        .i_busy     (i_busy),
        .o_wr       (o_wr),
        .o_data     (o_data),
        .o_line_cnt (o_line_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int model_cnt  = 0;
    int pushed     = 0;
    int rd_total   = 0;
    int wr_total   = 0;
    int overlap    = 0;
    int busy_viol  = 0;
    int extra_wr   = 0;
    int extra_rd   = 0;
    int cnt_over   = 0;
    int busy_cnt   = 0;
    int busy_hold  = 0;
    bit rand_busy  = 1'b0;
    bit last_sep   = 1'b1;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_digit(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(LETTER + n - 10);
    endfunction

    // Reference: what one popped byte must turn into on the serial line.
    task automatic expand(input logic [7:0] b);
        exp_q.push_back(hex_digit(int'(b) / 16));
        exp_q.push_back(hex_digit(int'(b) % 16));
        if (model_cnt == BPL - 1) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            model_cnt = 0;
        end else begin
            exp_q.push_back(8'h20);
            model_cnt++;
        end
    endtask

    task automatic refresh();
        i_empty = (fifo_q.size() == 0);
        i_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        pushed++;
        refresh();
    endtask

    task automatic tick();
        bit         rd_now, wr_now;
        logic [7:0] d;
        @(negedge clk);
        rd_now = o_rd;
        wr_now = o_wr;
        d      = o_data;
        if (rd_now && wr_now) overlap++;
        if (int'(o_line_cnt) > BPL - 1) cnt_over++;
        if (wr_now) begin
            wr_total++;
            if (i_busy) busy_viol++;
            if (exp_q.size() == 0) extra_wr++;
            else check("char", d, exp_q.pop_front());
            last_sep = (d == 8'h20) || (d == 8'h0A);
        end
        if (rd_now) begin
            rd_total++;
            check("rd_after_sep", last_sep, 1);
            check("line_cnt_at_rd", o_line_cnt, model_cnt);
            if (fifo_q.size() == 0) extra_rd++;
            else expand(fifo_q[0]);
        end
        @(posedge clk);
        #1;
        if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (busy_cnt > 0) busy_cnt--;
        if (wr_now) busy_cnt = rand_busy ? int'($urandom_range(0, 6)) : busy_hold;
        i_busy = (busy_cnt > 0);
        refresh();
    endtask

    task automatic drain();
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check("drain_left", fifo_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int wr_before;
        i_rst_n = 1'b0;
        i_busy  = 1'b0;
        refresh();
        repeat (3) tick();
        check("rst_rd", o_rd, 0);
        check("rst_wr", o_wr, 0);
        check("rst_data", o_data, 0);
        check("rst_line_cnt", o_line_cnt, 0);
        i_rst_n = 1'b1;
        tick();

        // One full line: 00 0f f0 ff CR LF
        push(8'h00); push(8'h0F); push(8'hF0); push(8'hFF);
        drain();
        check("line_cnt_wrap", o_line_cnt, 0);

        push(8'hA5);
        drain();
        check("line_cnt_a5", o_line_cnt, 1);

        // Slow serial_tx: busy for 100 cycles after every write
        busy_hold = 100;
        push(8'($urandom)); push(8'($urandom));
        drain();
        busy_hold = 0;

        // Random bytes arriving at random times with random busy lengths
        rand_busy = 1'b1;
        for (int i = 0; i < 26; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 30)) tick();
        end
        drain();
        rand_busy = 1'b0;
        repeat (10) tick();
        check("line_cnt_rand", o_line_cnt, model_cnt);

        // Reset while byte 3c is in its LO character
        push(8'h3C); push(8'h77);
        wr_before = wr_total;
        n = 0;
        while (wr_total == wr_before && n < 1000) begin
            tick();
            n++;
        end
        check("hi_written", wr_total - wr_before, 1);
        tick();
        i_rst_n = 1'b0;
        #1;
        check("midrst_wr", o_wr, 0);
        check("midrst_rd", o_rd, 0);
        check("midrst_data", o_data, 0);
        check("midrst_line_cnt", o_line_cnt, 0);
        exp_q.delete();
        model_cnt = 0;
        last_sep  = 1'b1;
        busy_cnt  = 0;
        i_busy    = 1'b0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        drain();
        check("line_cnt_post_rst", o_line_cnt, 1);

        check("rd_total", rd_total, pushed);
        check("overlap", overlap, 0);
        check("busy_viol", busy_viol, 0);
        check("extra_wr", extra_wr, 0);
        check("extra_rd", extra_rd, 0);
        check("cnt_over", cnt_over, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    always @(posedge clk) begin
        assert (!(o_rd && o_wr));
    end

endmodule

// File: doc/hex_dump_tx.md
Name: hex_dump_tx

Overview:
- Formatter stage between the RX byte fifo and `serial_tx`.
- Pops raw bytes from the fifo and emits each as two ASCII hex digits followed by a separator, feeding `serial_tx` one character at a time.
- Separator is a space, except after every BYTES_PER_LINE bytes, when it is CR then LF.
- Turns the UART loopback into a hex dump for inspecting line traffic on Fomu.

Parameters:
- BYTES_PER_LINE, 16, bytes per output line before CR LF is emitted; legal range 1..255.

Ports:
- i_clk  input  1  system clock, 48 MHz
- i_rst_n  input  1  asynchronous active-low reset
- i_empty  input  1  fifo empty flag
- i_data  input  8  fifo head byte (first-word-fall-through; valid while i_empty=0)
- o_rd  output  1  fifo pop strobe; head byte consumed in the same cycle
- i_busy  input  1  serial_tx busy
- o_wr  output  1  serial_tx write strobe, one cycle
- o_data  output  8  ASCII character to serial_tx, valid when o_wr=1
- o_line_cnt  output  8  bytes emitted on the current line (0..BYTES_PER_LINE-1)

Behaviour:
- Reset (async assert, sync deassert in the caller's clock domain): state=IDLE, o_rd=0, o_wr=0, o_data=8'h00, o_line_cnt=0, byte register=0.
- States: IDLE, HI, LO, SEP, CR, LF, GAP.
- IDLE:
  - If i_empty=0, assert o_rd for exactly one cycle, latch i_data into the byte register, go to HI.
  - If i_empty=1, o_rd=0 and stay in IDLE.
- Character states (HI, LO, SEP, CR, LF):
  - Wait until i_busy=0, then assert o_wr for one cycle with o_data registered, and go to GAP.
  - GAP is one cycle and ignores i_busy, covering serial_tx's one-cycle busy latency. It then advances to the next character state.
- Character sequence per byte:
  - HI = digit(byte[7:4]), then LO = digit(byte[3:0]).
  - If o_line_cnt == BYTES_PER_LINE-1: CR (8'h0D), then LF (8'h0A), then o_line_cnt <= 0.
  - Otherwise: SEP (8'h20), then o_line_cnt <= o_line_cnt+1.
  - Then return to IDLE.
- digit(n): n<10 -> 8'h30+n; n>=10 -> lowercase 8'h61+(n-10), or uppercase when the feature is enabled.
- Throughput:
  - Minimum 2 cycles per character.
  - Each byte adds 1 IDLE cycle.
  - In practice, each character is bounded by the serial_tx frame time (~4167 cycles at 115200 baud).
- o_rd and o_wr are never asserted in the same cycle. Only one byte is in flight at a time, so the fifo absorbs bursts.
- If i_empty rises while a byte is being formatted, there is no effect: the latched byte completes.
- BYTES_PER_LINE=1: every byte is followed by CR LF; o_line_cnt stays 0.
- o_line_cnt wraps only via the CR/LF path; it never exceeds BYTES_PER_LINE-1.
- Reset mid-character: an in-progress formatted byte is lost. No partial o_wr is issued after reset deasserts. serial_tx completes any frame it already accepted on its own.

Optional Feature:
- Macro HEX_DUMP_UPPER_EN.
- Defined: hex letters are uppercase, 8'h41..8'h46 ("A".."F").
- Undefined: lowercase, 8'h61..8'h66 ("a".."f").
- Digits 0-9 are unaffected.

Decomposition:
- Shared package `uart_pkg`:
  - ASCII constants: ASCII_SP=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A_LO=8'h61, ASCII_A_UP=8'h41.
  - State encoding localparams.
- One sub-module: `nibble_to_ascii`, a combinational 4-bit -> 8-bit converter honouring HEX_DUMP_UPPER_EN, instantiated once with the nibble mux on its input.

Test Plan:
- Single byte 8'hA5, BYTES_PER_LINE=16, i_busy held 0 -> o_wr strobes carry 8'h61, 8'h35, 8'h20 in order. Exactly one o_rd. o_line_cnt 0->1.
- Same with HEX_DUMP_UPPER_EN defined -> 8'h41, 8'h35, 8'h20.
- 4 bytes 00,0F,F0,FF with BYTES_PER_LINE=4 -> "00 0f f0 ff" then 8'h0D, 8'h0A and no trailing space. o_line_cnt returns to 0.
- i_busy held 1 for 100 cycles after each o_wr, 2 bytes queued -> no o_wr while i_busy=1. Character order is preserved. The second o_rd occurs only after the first byte's separator is written.
- Back-to-back: 20 bytes queued, BYTES_PER_LINE=16 -> CR LF after byte 16 only. o_line_cnt=4 at the end. No o_rd/o_wr overlap (assertion).
- Assert i_rst_n=0 during LO of byte 8'h3C -> all outputs go to reset values immediately. After release, the next queued byte is formatted from HI with o_line_cnt=0.
